sequence_scheduler: RTL

Parametrised successor of the PA-command sequence counter: walks a command memory from address 0 to `seq_end_addr`, issuing a one-cycle write strobe to the Manchester encoder per step with a programmable gap between strobes. Adds single-shot, continuous-loop and N-repeat modes, pass/sequence completion pulses, a busy flag and a synchronous reset. Sits between the txrx control logic and the command RAM / Manchester encoder.

---
 rtl/seq_pkg.sv | 18 +
 rtl/sequence_scheduler_if.sv | 37 +++
 rtl/seq_gap_timer.sv | 40 ++++
 rtl/sequence_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the command-sequence scheduler.
// Optional per-step gap feature is selected with SEQ_STEP_GAP_EN.
package seq_pkg;
  localparam int SEQ_ADDR_W = 7;
  localparam int SEQ_GAP_W  = 16;
  localparam int SEQ_REP_W  = 8;

  localparam logic [1:0] SEQ_MODE_SINGLE = 2'd0;
  localparam logic [1:0] SEQ_MODE_LOOP   = 2'd1;
  localparam logic [1:0] SEQ_MODE_REPEAT = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} seq_state_e;

  // Mode 3 is undefined and behaves as single-shot.
  function automatic logic [1:0] seq_norm_mode(input logic [1:0] m);
    return (m == SEQ_MODE_LOOP || m == SEQ_MODE_REPEAT) ? m : SEQ_MODE_SINGLE;
  endfunction
endpackage

// File: rtl/sequence_scheduler_if.sv
// Control/status bundle between txrx control (master) and the scheduler (slave).
// gap_rd_data exists only when SEQ_STEP_GAP_EN is defined.
interface sequence_scheduler_if #(
  parameter int ADDR_W = seq_pkg::SEQ_ADDR_W,
  parameter int GAP_W  = seq_pkg::SEQ_GAP_W,
  parameter int REP_W  = seq_pkg::SEQ_REP_W
) ();
  logic              ctr_en;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] seq_end_addr;
  logic [REP_W-1:0]  repeat_cnt;
  logic [GAP_W-1:0]  time_gap;
`ifdef SEQ_STEP_GAP_EN
  logic [GAP_W-1:0]  gap_rd_data;
`endif
  logic [ADDR_W-1:0] seq_addr;
  logic              manchester_wren;
  logic              busy;
  logic              pass_done;
  logic              seq_done;

  modport master (
    output ctr_en, mode, seq_end_addr, repeat_cnt, time_gap,
`ifdef SEQ_STEP_GAP_EN
    output gap_rd_data,
`endif
    input  seq_addr, manchester_wren, busy, pass_done, seq_done
  );

  modport slave (
    input  ctr_en, mode, seq_end_addr, repeat_cnt, time_gap,
`ifdef SEQ_STEP_GAP_EN
    input  gap_rd_data,
`endif
    output seq_addr, manchester_wren, busy, pass_done, seq_done
  );
endinterface

// File: rtl/seq_gap_timer.sv
// Inter-strobe gap counter: load restarts at 1 and captures the gap (0 read as 1),
// expire_o flags the cycle the count reaches the captured gap.
module seq_gap_timer #(
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             expire_o
);
  logic [GAP_W-1:0] cnt_q, cnt_d, gap_q, gap_d;

  always_comb begin
    cnt_d = cnt_q;
    gap_d = gap_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = GAP_W'(1);
      gap_d = (gap_i == '0) ? GAP_W'(1) : gap_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      gap_q <= GAP_W'(1);
    end else begin
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end

  // A cleared counter (0) never matches since gap_q is always >= 1.
  assign expire_o = (cnt_q == gap_q);
endmodule

// File: rtl/sequence_scheduler.sv
// Walks command memory 0..seq_end_addr issuing one write strobe per step with a
// programmable gap; single/loop/repeat modes. SEQ_STEP_GAP_EN selects per-step RAM gaps.
module sequence_scheduler
  import seq_pkg::*;
#(
  parameter int ADDR_W = SEQ_ADDR_W,
  parameter int GAP_W  = SEQ_GAP_W,
  parameter int REP_W  = SEQ_REP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_scheduler_if.slave  bus
);
  seq_state_e        state_q, state_d;
  logic              en_q;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [REP_W-1:0]  passes_q, passes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wren_q, wren_d, pass_q, pass_d, sdone_q, sdone_d, busy_q, busy_d;

  logic              expire, strobe;
  logic [ADDR_W-1:0] k, end_v;
  logic [1:0]        mode_v;
  logic [REP_W-1:0]  passes_v;
  logic [GAP_W-1:0]  gap_src;

`ifdef SEQ_STEP_GAP_EN
  assign gap_src = bus.gap_rd_data;
`else
  assign gap_src = bus.time_gap;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    end_d    = end_q;
    passes_d = passes_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    wren_d   = 1'b0;
    pass_d   = 1'b0;
    sdone_d  = 1'b0;
    strobe   = 1'b0;
    k        = addr_q;
    end_v    = end_q;
    mode_v   = mode_q;
    passes_v = passes_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        addr_d = '0;
        if (bus.ctr_en && !en_q) begin
          strobe   = 1'b1;
          k        = '0;
          end_v    = bus.seq_end_addr;
          mode_v   = seq_norm_mode(bus.mode);
          passes_v = (bus.repeat_cnt == '0) ? REP_W'(1) : bus.repeat_cnt;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.ctr_en) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          addr_d  = '0;
        end else if (expire) begin
          strobe = 1'b1;
        end
      end
      default: begin
        // busy_q is still high only on the first DONE cycle -> one-shot seq_done.
        busy_d  = 1'b0;
        addr_d  = '0;
        sdone_d = busy_q;
        if (!bus.ctr_en) begin
          state_d = ST_IDLE;
          sdone_d = 1'b0;
        end
      end
    endcase

    if (strobe) begin
      wren_d   = 1'b1;
      mode_d   = mode_v;
      end_d    = end_v;
      passes_d = passes_v;
      if (k == end_v) begin
        pass_d = 1'b1;
        addr_d = '0;
        if (mode_v == SEQ_MODE_REPEAT && passes_v > REP_W'(1))
          passes_d = passes_v - REP_W'(1);
        else if (mode_v != SEQ_MODE_LOOP)
          state_d = ST_DONE;
      end else begin
        addr_d = k + ADDR_W'(1);
      end
    end
  end

  seq_gap_timer #(.GAP_W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != ST_RUN),
    .load_i   (strobe),
    .gap_i    (gap_src),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= SEQ_MODE_SINGLE;
      end_q    <= '0;
      passes_q <= '0;
      addr_q   <= '0;
      wren_q   <= 1'b0;
      pass_q   <= 1'b0;
      sdone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= bus.ctr_en;
      mode_q   <= mode_d;
      end_q    <= end_d;
      passes_q <= passes_d;
      addr_q   <= addr_d;
      wren_q   <= wren_d;
      pass_q   <= pass_d;
      sdone_q  <= sdone_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.seq_addr        = addr_q;
  assign bus.manchester_wren = wren_q;
  assign bus.pass_done       = pass_q;
  assign bus.seq_done        = sdone_q;
  assign bus.busy            = busy_q;
endmodule
